// File: rtl/passcode_lock.sv
// rtl/passcode_lock.sv - framed serial passcode checker with failure lockout
//
// Ports:
//   clk          rising-edge clock
//   asyncResetN  asynchronous active-low reset
//   dataIn       serial code bit, MSB of each group first
//   dataValid    qualifies dataIn this cycle
//   abortIn      drops the partially received group (wins over dataValid)
//   detectOut    one-cycle pulse: completed group matched a code
//   matchIdx     lowest matching code index, held until the next match
//   failOut      one-cycle pulse: completed group matched no code
//   failCount    consecutive failures since last match or lockout
//   lockedOut    high while locked out
module passcode_lock #(
    parameter int CODE_LEN       = 4,
    parameter int NUM_CODES      = 2,
    parameter logic [CODE_LEN*NUM_CODES-1:0] CODES = 8'b1001_0101,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic asyncResetN,
    input  logic dataIn,
    input  logic dataValid,
    input  logic abortIn,
    output logic detectOut,
    output logic [((NUM_CODES > 1) ? $clog2(NUM_CODES) : 1)-1:0] matchIdx,
    output logic failOut,
    output logic [$clog2(MAX_FAILS+1)-1:0] failCount,
    output logic lockedOut
);

    localparam int IDX_W  = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int BIT_W  = $clog2(CODE_LEN);
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [IDX_W-1:0]    match_idx_q, match_idx_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic                detect_q, detect_d;
    logic                fail_q, fail_d;

    // The group as it stands once this cycle's bit is included; only
    // meaningful on the cycle that samples the last bit.
    logic [CODE_LEN-1:0] group;
    logic [FAIL_W-1:0]   fail_inc;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;

    assign group    = {shift_q[CODE_LEN-2:0], dataIn};
    assign fail_inc = fail_cnt_q + 1'b1;

    // Scan from the top index down so the lowest matching index is left last.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CODES - 1; i >= 0; i--) begin
            if (group == CODES[i*CODE_LEN +: CODE_LEN]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        match_idx_d = match_idx_q;
        fail_cnt_d  = fail_cnt_q;
        detect_d    = 1'b0;
        fail_d      = 1'b0;
        case (state_q)
            COLLECT: begin
                if (abortIn) begin
                    bit_cnt_d = '0;
                end else if (dataValid) begin
                    shift_d = group;
                    if (bit_cnt_q == BIT_W'(CODE_LEN - 1)) begin
                        bit_cnt_d = '0;
                        if (hit) begin
                            detect_d    = 1'b1;
                            match_idx_d = hit_idx;
                            fail_cnt_d  = '0;
                        end else begin
                            fail_d     = 1'b1;
                            fail_cnt_d = fail_inc;
                            if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                                state_d    = LOCKED;
                                lock_cnt_d = LOCK_W'(LOCKOUT_CYCLES - 1);
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                // Counter loaded with LOCKOUT_CYCLES-1 and exit taken after
                // it reads 0 gives exactly LOCKOUT_CYCLES locked cycles.
                if (lock_cnt_q == '0) begin
                    state_d    = COLLECT;
                    fail_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge asyncResetN) begin
        if (!asyncResetN) begin
            state_q     <= COLLECT;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            lock_cnt_q  <= '0;
            match_idx_q <= '0;
            fail_cnt_q  <= '0;
            detect_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            match_idx_q <= match_idx_d;
            fail_cnt_q  <= fail_cnt_d;
            detect_q    <= detect_d;
            fail_q      <= fail_d;
        end
    end

    assign detectOut = detect_q;
    assign failOut   = fail_q;
    assign matchIdx  = match_idx_q;
    assign failCount = fail_cnt_q;
    assign lockedOut = (state_q == LOCKED);

endmodule

// File: tb/tb_passcode_lock.sv
// tb/tb_passcode_lock.sv - scoreboard bench for passcode_lock (default and 6-bit/3-code builds)
module tb_passcode_lock;

    localparam int MAXF  = 3;
    localparam int LOCKC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       d0, v0, a0, det0, fail0, lk0, m0;
    logic [1:0] fc0;
    logic       d1, v1, a1, det1, fail1, lk1;
    logic [1:0] m1, fc1;

    passcode_lock u_dut0 (
        .clk(clk), .asyncResetN(rst_n), .dataIn(d0), .dataValid(v0), .abortIn(a0),
        .detectOut(det0), .matchIdx(m0), .failOut(fail0), .failCount(fc0), .lockedOut(lk0)
    );

    passcode_lock #(
        .CODE_LEN(6), .NUM_CODES(3), .CODES({6'h3F, 6'h15, 6'h2A})
    ) u_dut1 (
        .clk(clk), .asyncResetN(rst_n), .dataIn(d1), .dataValid(v1), .abortIn(a1),
        .detectOut(det1), .matchIdx(m1), .failOut(fail1), .failCount(fc1), .lockedOut(lk1)
    );

    typedef struct packed {
        logic det;
        int   fc;
        logic lk;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    // Reference model: a group is an integer built MSB-first, compared
    // against a table of code values.
    int len[2]         = '{4, 6};
    int ncodes[2]      = '{2, 3};
    int code_tab[2][3] = '{'{5, 9, 0}, '{42, 21, 63}};
    int cnt[2], val[2], fails[2], lock_left[2], midx[2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; val[k] = 0; fails[k] = 0; lock_left[k] = 0; midx[k] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_edge(int k, logic v, logic d, logic a);
        exp_t e;
        int   hitv;
        if (lock_left[k] > 0) begin
            lock_left[k]--;
            if (lock_left[k] == 0) fails[k] = 0;
        end else if (a) begin
            cnt[k] = 0;
            val[k] = 0;
        end else if (v) begin
            val[k] = val[k] * 2 + int'(d);
            cnt[k]++;
            if (cnt[k] == len[k]) begin
                hitv = -1;
                for (int i = 0; i < ncodes[k]; i++)
                    if (code_tab[k][i] == val[k] && hitv < 0) hitv = i;
                if (hitv >= 0) begin
                    midx[k]  = hitv;
                    fails[k] = 0;
                    e = '{det: 1'b1, fc: 0, lk: 1'b0};
                end else begin
                    fails[k]++;
                    if (fails[k] == MAXF) lock_left[k] = LOCKC;
                    e = '{det: 1'b0, fc: fails[k], lk: (lock_left[k] > 0)};
                end
                if (k == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                cnt[k] = 0;
                val[k] = 0;
            end
        end
    endtask

    // Called at posedge+1; drives one cycle to DUT k, the other idles.
    task automatic step(int k, logic v, logic d, logic a);
        v0 = (k == 0) ? v : 1'b0; d0 = (k == 0) ? d : 1'b0; a0 = (k == 0) ? a : 1'b0;
        v1 = (k == 1) ? v : 1'b0; d1 = (k == 1) ? d : 1'b0; a1 = (k == 1) ? a : 1'b0;
        @(posedge clk);
        model_edge(0, v0, d0, a0);
        model_edge(1, v1, d1, a1);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(int k, int value);
        for (int i = len[k] - 1; i >= 0; i--) step(k, 1'b1, 1'((value >> i) & 1), 1'b0);
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int q_size(int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic exp_t q_pop(int k);
        if (k == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    task automatic mon(int k, logic det, logic fl, int idx, int fc, logic lk);
        exp_t e;
        chk($sformatf("locked%0d", k), int'(lk), int'(lock_left[k] > 0));
        chk($sformatf("fail_count%0d", k), fc, fails[k]);
        chk($sformatf("match_idx%0d", k), idx, midx[k]);
        if (det || fl) begin
            if (q_size(k) == 0) begin
                chk($sformatf("unexpected_pulse%0d", k), 1, 0);
            end else begin
                e = q_pop(k);
                chk($sformatf("pulse_kind%0d", k), int'(det), int'(e.det));
                chk($sformatf("pulse_both%0d", k), int'(det && fl), 0);
                chk($sformatf("pulse_fail_count%0d", k), fc, e.fc);
                chk($sformatf("pulse_locked%0d", k), int'(lk), int'(e.lk));
            end
        end else if (q_size(k) > 0) begin
            e = q_pop(k);
            chk($sformatf("missing_pulse%0d", k), 0, 1);
        end
    endtask

    always @(negedge clk) begin
        mon(0, det0, fail0, int'(m0), int'(fc0), lk0);
        mon(1, det1, fail1, int'(m1), int'(fc1), lk1);
    end

    initial begin
        int k, value;
        rst_n = 1'b0;
        v0 = 0; d0 = 0; a0 = 0; v1 = 0; d1 = 0; a1 = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(10);

        send(0, 5); send(0, 9);
        step(0, 1, 0, 0); step(0, 1, 1, 0); idle(3); step(0, 1, 0, 0); step(0, 1, 1, 0);
        step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 1);
        send(0, 5);
        idle(2);

        send(0, 0); send(0, 15); send(0, 3);
        send(0, 5);
        idle(14);
        send(0, 5);
        idle(2);

        send(0, 0); send(0, 0); send(0, 9);
        idle(2);

        step(0, 1, 0, 0); step(0, 1, 1, 0);
        reset_mid();
        send(0, 5);
        idle(2);

        send(1, 63); send(1, 42); send(1, 21); send(1, 0);
        idle(2);

        repeat (80) begin
            k = int'($urandom_range(0, 1));
            if ($urandom % 3 != 0)
                value = code_tab[k][$urandom_range(0, ncodes[k] - 1)];
            else
                value = int'($urandom_range(0, (1 << len[k]) - 1));
            for (int i = len[k] - 1; i >= 0; i--) begin
                if ($urandom % 4 == 0) step(k, 1'b0, 1'($urandom % 2), 1'b0);
                if ($urandom % 30 == 0) step(k, 1'($urandom % 2), 1'($urandom % 2), 1'b1);
                step(k, 1'b1, 1'((value >> i) & 1), 1'b0);
            end
        end

        idle(20);
        chk("queue_empty0", exp_q0.size(), 0);
        chk("queue_empty1", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
